// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between the
// I-side (read-only fetch) and the D-side (load/store). One access in flight.
// D-side has priority; after MAX_WAIT consecutive losses the I-side wins.
// Ports:
//   clk, rst (sync, active-low)
//   i_req/i_addr -> i_done/i_rdata          I-side request / completion
//   d_req/d_wr/d_addr/d_wdata -> d_done/d_rdata   D-side request / completion
//   mem_en/mem_wr/mem_addr/mem_wdata, mem_rdata   memory interface
//   busy                                    access in flight
//   i_grant_cnt/d_grant_cnt                 saturating per-side grant totals
module mem_arbiter #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned LAT      = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [15:0]   i_grant_cnt,
  output logic [15:0]   d_grant_cnt
);

  localparam int unsigned CW = $clog2(LAT + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam int unsigned GW = 16;
  localparam logic [GW-1:0] GMAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [WW-1:0] iWait, iWaitNext;
  logic [GW-1:0] iCntNext, dCntNext;
  logic          iElig, dElig, grantI, grantD, finish;

  // Arbitration and access sequencing
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    iWaitNext = iWait;
    grantI    = 1'b0;
    grantD    = 1'b0;
    finish    = 1'b0;
    // A side whose done is high this cycle is dropping its request
    iElig     = i_req && !i_done;
    dElig     = d_req && !d_done;
    case (state)
      IDLE: begin
        if (iElig && (!dElig || iWait == WW'(MAX_WAIT))) begin
          grantI    = 1'b1;
          stateNext = BUSY_I;
          cntNext   = CW'(1);
          iWaitNext = '0;
        end else if (dElig) begin
          grantD    = 1'b1;
          stateNext = BUSY_D;
          cntNext   = CW'(1);
          // D only beats an eligible I while iWait < MAX_WAIT, so this saturates
          if (iElig) iWaitNext = iWait + WW'(1);
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt == CW'(LAT)) begin
          finish    = 1'b1;
          stateNext = IDLE;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
    iCntNext = (grantI && i_grant_cnt != GMAX) ? i_grant_cnt + GW'(1) : i_grant_cnt;
    dCntNext = (grantD && d_grant_cnt != GMAX) ? d_grant_cnt + GW'(1) : d_grant_cnt;
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      iWait       <= '0;
      i_grant_cnt <= '0;
      d_grant_cnt <= '0;
      busy        <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      iWait       <= iWaitNext;
      i_grant_cnt <= iCntNext;
      d_grant_cnt <= dCntNext;
      busy        <= (stateNext != IDLE);
      // Strobe lands in the first BUSY cycle (cnt==1)
      mem_en      <= grantI || grantD;
      i_done      <= finish && (state == BUSY_I);
      d_done      <= finish && (state == BUSY_D);
      if (finish && state == BUSY_I) i_rdata <= mem_rdata;
      if (finish && state == BUSY_D && !mem_wr) d_rdata <= mem_rdata;
      // Captured request drives the memory bus for all of BUSY, zero in IDLE
      if (grantI) begin
        mem_addr  <= i_addr;
        mem_wr    <= 1'b0;
        mem_wdata <= '0;
      end else if (grantD) begin
        mem_addr  <= d_addr;
        mem_wr    <= d_wr;
        mem_wdata <= d_wdata;
      end else if (finish) begin
        mem_addr  <= '0;
        mem_wr    <= 1'b0;
        mem_wdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned AW       = 16;
  localparam int unsigned DW       = 16;
  localparam int unsigned LAT      = 4;
  localparam int unsigned MAX_WAIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_done, d_done, mem_en, mem_wr, busy;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [15:0]   i_grant_cnt, d_grant_cnt;

  int checks = 0;
  int errors = 0;
  int expICnt = 0;
  int expDCnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  // Memory stub: 256 words, data presented only in the cnt==LAT cycle
  logic [DW-1:0] stubMem [256];
  logic [DW-1:0] refMem  [256];
  int            stubAge = 0;
  logic [7:0]    stubAddr = 8'h00;
  logic          plEn = 1'b0;
  logic [7:0]    plAddr = 8'h00;
  logic [DW-1:0] plData = '0;

  always @(posedge clk) begin
    if (plEn) stubMem[plAddr] <= plData;
    else if (mem_en && mem_wr) stubMem[mem_addr[7:0]] <= mem_wdata;
    if (!rst) stubAge <= 0;
    else if (mem_en) begin
      stubAge  <= 2;
      stubAddr <= mem_addr[7:0];
    end else if (stubAge != 0 && stubAge < int'(LAT)) stubAge <= stubAge + 1;
    else stubAge <= 0;
  end

  always_comb begin
    if (mem_en && LAT == 1) mem_rdata = stubMem[mem_addr[7:0]];
    else if (!mem_en && stubAge == int'(LAT)) mem_rdata = stubMem[stubAddr];
    else mem_rdata = 16'hDEAD;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] v);
    plEn = 1'b1; plAddr = a; plData = v;
    step();
    plEn = 1'b0;
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 20 && (busy || i_done || d_done); k++) step();
    checks++;
    if (busy !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL waitIdle: busy=%b i_done=%b d_done=%b, required all 0", busy, i_done, d_done);
    end
  endtask

  function automatic logic [119:0] outVec();
    return {busy, mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done,
            i_rdata, d_rdata, i_grant_cnt, d_grant_cnt, 3'b000};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    idleInputs();
    for (int k = 0; k < 256; k++) preload(8'(k), DW'(k * 37 + 5));
    step();
    checks++;
    if (outVec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", outVec());
    end
    rst = 1'b1;
    step(); step();
    checks++;
    if (outVec() !== '0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h, required 0", outVec());
    end
  endtask

  task automatic test_single_fetch();
    preload(8'h40, 16'hBEEF);
    i_req = 1'b1; i_addr = 16'h0040;
    step();
    expICnt++;
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0040 || mem_wr !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_cycle1: en=%b addr=%h wr=%b busy=%b, required 1 0040 0 1", mem_en, mem_addr, mem_wr, busy);
    end
    i_req = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      step();
      checks++;
      if (busy !== 1'b1 || mem_en !== 1'b0 || i_done !== 1'b0) begin
        errors++;
        $display("FAIL fetch_busy c%0d: busy=%b en=%b done=%b, required 1 0 0", c, busy, mem_en, i_done);
      end
    end
    step();
    checks++;
    if (i_done !== 1'b1 || i_rdata !== 16'hBEEF || i_grant_cnt !== 16'(expICnt) || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: done=%b rdata=%h cnt=%0d busy=%b, required 1 beef %0d 0", i_done, i_rdata, i_grant_cnt, busy, expICnt);
    end
    step();
    checks++;
    if (i_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done_pulse: i_done=%b, required 0", i_done);
    end
  endtask

  task automatic test_priority();
    preload(8'h22, 16'h5A5A);
    preload(8'h33, 16'h1111);
    i_req = 1'b1; i_addr = 16'h0033;
    d_req = 1'b1; d_addr = 16'h0022; d_wr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0022) begin
          errors++;
          $display("FAIL prio_first: en=%b addr=%h, required 1 0022", mem_en, mem_addr);
        end
        d_req = 1'b0;
      end
      if (c == 6) begin
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0033) begin
          errors++;
          $display("FAIL prio_second: en=%b addr=%h, required 1 0033", mem_en, mem_addr);
        end
        i_req = 1'b0;
      end
      checks++;
      if (d_done !== (c == 5) || i_done !== (c == 10)) begin
        errors++;
        $display("FAIL prio_done c%0d: d_done=%b i_done=%b, required %b %b", c, d_done, i_done, c == 5, c == 10);
      end
      if (c == 5) begin
        checks++;
        if (d_rdata !== 16'h5A5A) begin
          errors++;
          $display("FAIL prio_drdata: got %h, required 5a5a", d_rdata);
        end
      end
      if (c == 10) begin
        checks++;
        if (i_rdata !== 16'h1111) begin
          errors++;
          $display("FAIL prio_irdata: got %h, required 1111", i_rdata);
        end
      end
    end
    expICnt++; expDCnt++;
    checks++;
    if (i_grant_cnt !== 16'(expICnt) || d_grant_cnt !== 16'(expDCnt)) begin
      errors++;
      $display("FAIL prio_counts: i=%0d d=%0d, required %0d %0d", i_grant_cnt, d_grant_cnt, expICnt, expDCnt);
    end
  endtask

  task automatic test_starvation();
    logic [4:0] expSeq = 5'b10111;  // grant order LSB first: D D D I D
    int grants = 0;
    preload(8'h0A, 16'hAAAA);
    preload(8'h0D, 16'hDDDD);
    i_addr = 16'h000A; d_addr = 16'h000D; d_wr = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int cyc = 0; cyc < 80 && grants < 5; cyc++) begin
      step();
      checks++;
      if (i_done === 1'b1 && d_done === 1'b1) begin
        errors++;
        $display("FAIL starve_both_done: cycle %0d both dones high, required at most one", cyc);
      end
      if (mem_en === 1'b1) begin
        checks++;
        if ((mem_addr == 16'h000D) !== expSeq[grants]) begin
          errors++;
          $display("FAIL starve_order grant%0d: addr=%h, required side %s", grants, mem_addr, expSeq[grants] ? "D" : "I");
        end
        grants++;
      end
      // The I requester lets go during D's done cycle so both contend next
      i_req = (grants < 5) ? !d_done : 1'b0;
      d_req = (grants < 5);
    end
    checks++;
    if (grants != 5) begin
      errors++;
      $display("FAIL starve_timeout: saw %0d grants, required 5", grants);
    end
    idleInputs();
    waitIdle();
    expDCnt += 4; expICnt += 1;
    checks++;
    if (i_grant_cnt !== 16'(expICnt) || d_grant_cnt !== 16'(expDCnt)) begin
      errors++;
      $display("FAIL starve_counts: i=%0d d=%0d, required %0d %0d", i_grant_cnt, d_grant_cnt, expICnt, expDCnt);
    end
  endtask

  task automatic test_write();
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        checks++;
        if (mem_en !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0100) begin
          errors++;
          $display("FAIL write_cycle1: en=%b wr=%b wdata=%h addr=%h, required 1 1 1234 0100", mem_en, mem_wr, mem_wdata, mem_addr);
        end
        d_req = 1'b0;
      end else if (c <= 4) begin
        checks++;
        if (mem_en !== 1'b0) begin
          errors++;
          $display("FAIL write_strobe c%0d: mem_en=%b, required 0", c, mem_en);
        end
      end else begin
        checks++;
        if (d_done !== (c == 5) || d_rdata !== 16'hDDDD) begin
          errors++;
          $display("FAIL write_done c%0d: done=%b rdata=%h, required %b dddd", c, d_done, d_rdata, c == 5);
        end
      end
    end
    idleInputs();
    expDCnt++;
  endtask

  task automatic test_reset_midaccess();
    preload(8'h55, 16'hCAFE);
    i_req = 1'b1; i_addr = 16'h0055;
    step();
    i_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if (outVec() !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h, required 0", outVec());
    end
    rst = 1'b1;
    expICnt = 0; expDCnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (i_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale k%0d: i_done=%b busy=%b, required 0 0", k, i_done, busy);
      end
    end
    i_req = 1'b1; i_addr = 16'h0055;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) i_req = 1'b0;
      checks++;
      if (i_done !== (c == 5)) begin
        errors++;
        $display("FAIL reissue_done c%0d: i_done=%b, required %b", c, i_done, c == 5);
      end
    end
    expICnt++;
    checks++;
    if (i_rdata !== 16'hCAFE || i_grant_cnt !== 16'(expICnt)) begin
      errors++;
      $display("FAIL reissue_data: rdata=%h cnt=%0d, required cafe %0d", i_rdata, i_grant_cnt, expICnt);
    end
  endtask

  // Reference model: one outstanding transaction, tracked by side and age
  task automatic test_random();
    int mSide = 0;  // 0 none, 1 I, 2 D
    int mAge = 0, mWait = 0, mICnt = 0, mDCnt = 0;
    logic [AW-1:0] mAddr = '0;
    logic [DW-1:0] mWdata = '0, mIRd = '0, mDRd = '0;
    logic mWr = 1'b0, mIDone = 1'b0, mDDone = 1'b0;
    logic ie, de, nI, nD;
    logic [119:0] expV;
    rst = 1'b0; idleInputs();
    step(); step();
    rst = 1'b1;
    refMem = stubMem;
    for (int cyc = 0; cyc < 400; cyc++) begin
      expV = {mSide != 0, mSide != 0 && mAge == 1, mSide != 0 && mWr,
              mSide != 0 ? mAddr : AW'(0), mSide != 0 ? mWdata : DW'(0),
              mIDone, mDDone, mIRd, mDRd, 16'(mICnt), 16'(mDCnt), 3'b000};
      checks++;
      if (outVec() !== expV) begin
        errors++;
        $display("FAIL random cycle %0d: got %h, required %h", cyc, outVec(), expV);
      end
      rst = ($urandom % 150) != 0;
      if (!i_req) i_addr = AW'($urandom % 256);
      i_req = ($urandom % 4) != 0;
      if (!d_req) begin
        d_addr = AW'($urandom % 256);
        d_wr = $urandom % 3 == 0;
        d_wdata = DW'($urandom);
      end
      d_req = ($urandom % 3) != 0;
      // Advance the model across the coming posedge
      if (mSide != 0 && mAge == 1 && mWr) refMem[mAddr[7:0]] = mWdata;
      if (!rst) begin
        mSide = 0; mAge = 0; mWait = 0; mICnt = 0; mDCnt = 0;
        mIRd = '0; mDRd = '0; mIDone = 1'b0; mDDone = 1'b0;
      end else begin
        nI = 1'b0; nD = 1'b0;
        if (mSide != 0) begin
          if (mAge == int'(LAT)) begin
            if (mSide == 1) begin
              nI = 1'b1; mIRd = refMem[mAddr[7:0]];
            end else begin
              nD = 1'b1;
              if (!mWr) mDRd = refMem[mAddr[7:0]];
            end
            mSide = 0;
          end else mAge++;
        end else begin
          ie = i_req && !mIDone;
          de = d_req && !mDDone;
          if (ie && (!de || mWait == int'(MAX_WAIT))) begin
            mSide = 1; mAge = 1; mAddr = i_addr; mWr = 1'b0; mWdata = '0; mWait = 0;
            if (mICnt < 65535) mICnt++;
          end else if (de) begin
            mSide = 2; mAge = 1; mAddr = d_addr; mWr = d_wr; mWdata = d_wdata;
            if (ie && mWait < int'(MAX_WAIT)) mWait++;
            if (mDCnt < 65535) mDCnt++;
          end
        end
        mIDone = nI; mDDone = nD;
      end
      step();
    end
    rst = 1'b1;
    idleInputs();
    waitIdle();
  endtask

  task automatic test_saturation();
    preload(8'h77, 16'h7777);
    force dut.d_grant_cnt = 16'hFFFE;
    step();
    release dut.d_grant_cnt;
    checks++;
    if (d_grant_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL sat_preload: got %h, required fffe", d_grant_cnt);
    end
    for (int g = 0; g < 2; g++) begin
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0077;
      step();
      d_req = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || d_grant_cnt !== 16'hFFFF) begin
        errors++;
        $display("FAIL sat_grant%0d: en=%b cnt=%h, required 1 ffff", g, mem_en, d_grant_cnt);
      end
      for (int c = 2; c <= 5; c++) step();
      checks++;
      if (d_done !== 1'b1 || d_rdata !== 16'h7777) begin
        errors++;
        $display("FAIL sat_done%0d: done=%b rdata=%h, required 1 7777", g, d_done, d_rdata);
      end
      step();
    end
    checks++;
    if (d_grant_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: got %h, required ffff", d_grant_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    step();
    test_priority();
    step();
    test_starvation();
    step();
    test_write();
    step();
    test_reset_midaccess();
    step();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
